perceptron_weight_loader: RTL
=============================

// Module: perceptron_weight_loader
// PURPOSE
//   Upstream serializer for the perceptron datapath weight/bias shift registers.
//   Accepts one parallel {b, w0, w1} set per valid/ready handshake.
//   Streams each value MSB-first, one bit per clk, onto the datapath's 1-bit serial
//   ports, and drives the 2-bit select code that steers each bit into b, w0 or w1.
//   Order: b, then w0, then w1. Pulses done_o once the datapath holds the new set.
// PARAMETERS
//   WIDTH  8  bits per weight/bias; must equal datapath WIDTH; legal range >= 2
// PORTS
//   clk           in   1      clock; all state updates on posedge
//   reset         in   1      synchronous, active-high
//   load_valid_i  in   1      parallel weight set presented
//   load_ready_o  out  1      loader idle, can accept a set
//   b_load_i      in   WIDTH  bias to load (two's complement)
//   w0_load_i     in   WIDTH  weight 0 to load
//   w1_load_i     in   WIDTH  weight 1 to load
//   W1W0b_en_o    out  2      select: 00 none, 01 b, 10 w0, 11 w1
//   b_o           out  1      serial bias bit
//   W0_o          out  1      serial w0 bit
//   W1_o          out  1      serial w1 bit
//   busy_o        out  1      high in every non-IDLE state
//   done_o        out  1      1-cycle pulse: last bit shifted in
// BEHAVIOUR
//   States: IDLE -> SHIFT_B -> SHIFT_W0 -> SHIFT_W1 -> DONE -> IDLE.
//   Reset (any cycle, including mid-shift):
//     - next state IDLE, bit counter 0, shadow regs 0.
//     - outputs: W1W0b_en_o=00, b_o=W0_o=W1_o=0, busy_o=0, done_o=0, load_ready_o=1.
//   Handshake and capture:
//     - load_ready_o = (state==IDLE).
//     - Accept on the edge where load_valid_i & load_ready_o.
//     - That edge captures b/w0/w1 into shadow regs and enters SHIFT_B with counter 0.
//     - Inputs are ignored after acceptance; load_valid_i is ignored outside IDLE.
//   Serial streaming:
//     - SHIFT_x cycle k (k=0..WIDTH-1): W1W0b_en_o = code of x.
//     - Active bit line carries shadow_x[WIDTH-1-k]; the other two bit lines are 0.
//     - Outputs are decoded from registered state and shadow MSBs; no comb path from inputs.
//     - The datapath shifts left, inserting at LSB, so MSB-first leaves the value unreversed.
//     - Each SHIFT_x lasts exactly WIDTH cycles.
//     - Counter wraps WIDTH-1 -> 0 on a state advance; $clog2(WIDTH) bits, saturates nowhere.
//   Timing, accept edge = T:
//     - b enables:  cycles T+1 .. T+WIDTH.
//     - w0 enables: T+WIDTH+1 .. T+2*WIDTH.
//     - w1 enables: T+2*WIDTH+1 .. T+3*WIDTH.
//     - DONE state (done_o=1, en=00, ready=0): cycle T+3*WIDTH+1.
//     - IDLE/ready: from T+3*WIDTH+2.
//   Back-to-back: a new set may be accepted on the first IDLE cycle; min period 3*WIDTH+2.
//   Exactly 3*WIDTH enable cycles per accepted set; no gaps between segments.
//   Reset mid-load: the datapath shares reset, so its weights clear too.
//     - No partial set is retained; done_o does not fire for the aborted set.
// TESTING
//   Model the datapath shift registers in the bench and compare after each done_o.
//   1. WIDTH=8, b=0x05, w0=0x7F, w1=0x80, valid 1 cycle:
//      -> 24 enable cycles (8x01, 8x10, 8x11); model b=05, w0=7F, w1=80;
//      -> done_o high exactly at T+25.
//   2. Hold load_valid_i high continuously with changing data:
//      -> accepts only in IDLE, period 26 cycles;
//      -> mid-load data changes do not alter the shifted values.
//   3. Assert reset at T+10 (mid-w0):
//      -> next cycle en=00, bits 0, ready=1, busy=0; no done_o pulse;
//      -> a fresh load of b=0xFF, w0=0x01, w1=0x00 completes correctly.
//   4. Load b=0xAA, w0=0x55, w1=0xC3:
//      -> per-cycle bit sequence MSB-first (1,0,1,0,...);
//      -> inactive bit lines stay 0 throughout.
//   5. WIDTH=2, b=2'b10, w0=2'b01, w1=2'b11:
//      -> 6 enable cycles; done_o at T+7; model values exact.
//   6. Idle with load_valid_i=0 for 50 cycles:
//      -> en=00, busy_o=0, done_o=0, ready=1 throughout.

Source files
------------

// File: rtl/perceptron_weight_loader_if.sv
// Handshake and serial-load bundle between the weight source, the loader and
// the perceptron datapath's weight/bias shift registers.
interface perceptron_weight_loader_if #(
  parameter int WIDTH = 8
);
  logic             load_valid_i;
  logic             load_ready_o;
  logic [WIDTH-1:0] b_load_i;
  logic [WIDTH-1:0] w0_load_i;
  logic [WIDTH-1:0] w1_load_i;
  logic [1:0]       W1W0b_en_o;
  logic             b_o;
  logic             W0_o;
  logic             W1_o;
  logic             busy_o;
  logic             done_o;

  // The loader itself sits on the slave side of this bundle.
  modport slave (
    input  load_valid_i, b_load_i, w0_load_i, w1_load_i,
    output load_ready_o, W1W0b_en_o, b_o, W0_o, W1_o, busy_o, done_o
  );

  modport master (
    output load_valid_i, b_load_i, w0_load_i, w1_load_i,
    input  load_ready_o, W1W0b_en_o, b_o, W0_o, W1_o, busy_o, done_o
  );
endinterface

// File: rtl/perceptron_weight_loader.sv
// Serializes one parallel {b, w0, w1} weight set MSB-first into the perceptron
// datapath shift registers, steering each bit with a 2-bit select code.
module perceptron_weight_loader #(
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  perceptron_weight_loader_if.slave ld
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] EN_NONE = 2'b00;
  localparam logic [1:0] EN_B    = 2'b01;
  localparam logic [1:0] EN_W0   = 2'b10;
  localparam logic [1:0] EN_W1   = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT_B,
    SHIFT_W0,
    SHIFT_W1,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] w0_q, w0_d;
  logic [WIDTH-1:0] w1_q, w1_d;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      b_q     <= '0;
      w0_q    <= '0;
      w1_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      b_q     <= b_d;
      w0_q    <= w0_d;
      w1_q    <= w1_d;
    end
  end

  // Shadow registers shift left as bits are consumed, so the bit on the wire
  // is always the shadow MSB.
  always_comb begin
    // NOTE: every signal gets a default first so no path through the case
    // can leave one unassigned and infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    b_d     = b_q;
    w0_d    = w0_q;
    w1_d    = w1_q;

    unique case (state_q)
      IDLE: begin
        if (ld.load_valid_i) begin
          b_d     = ld.b_load_i;
          w0_d    = ld.w0_load_i;
          w1_d    = ld.w1_load_i;
          cnt_d   = '0;
          state_d = SHIFT_B;
        end
      end
      SHIFT_B: begin
        b_d   = {b_q[WIDTH-2:0], 1'b0};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = SHIFT_W0;
        end
      end
      SHIFT_W0: begin
        w0_d  = {w0_q[WIDTH-2:0], 1'b0};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = SHIFT_W1;
        end
      end
      SHIFT_W1: begin
        w1_d  = {w1_q[WIDTH-2:0], 1'b0};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs depend only on registered state and shadow MSBs.
  always_comb begin
    unique case (state_q)
      SHIFT_B:  ld.W1W0b_en_o = EN_B;
      SHIFT_W0: ld.W1W0b_en_o = EN_W0;
      SHIFT_W1: ld.W1W0b_en_o = EN_W1;
      default:  ld.W1W0b_en_o = EN_NONE;
    endcase
  end

  assign ld.load_ready_o = (state_q == IDLE);
  assign ld.busy_o       = (state_q != IDLE);
  assign ld.done_o       = (state_q == DONE);
  assign ld.b_o          = (state_q == SHIFT_B)  & b_q[WIDTH-1];
  assign ld.W0_o         = (state_q == SHIFT_W0) & w0_q[WIDTH-1];
  assign ld.W1_o         = (state_q == SHIFT_W1) & w1_q[WIDTH-1];
endmodule
